// File: rtl/stats_uart_tx_if.sv
// stats_uart_tx_if: trigger and snapshot inputs plus serial/status outputs of the stats transmitter
interface stats_uart_tx_if;
  logic       trigger;
  logic [4:0] hunger, happiness, health, hygiene, energy, social;
  logic [7:0] status;
  logic       is_sleeping;
  logic       tx, busy, frame_done;
  modport master (
    output trigger, hunger, happiness, health, hygiene, energy, social, status, is_sleeping,
    input  tx, busy, frame_done
  );
  modport slave (
    input  trigger, hunger, happiness, health, hygiene, energy, social, status, is_sleeping,
    output tx, busy, frame_done
  );
endinterface

// File: rtl/stats_uart_tx.sv
// stats_uart_tx: UART 8N1 sender of a fixed 10-byte pet-state frame, snapshotted on trigger
module stats_uart_tx #(
  parameter int CLKS_PER_BIT = 87
) (
  input logic            clk,
  input logic            rst_n,
  stats_uart_tx_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [3:0]    byte_idx;
  logic          pending;
  logic [7:0]    frame [10];
  logic [7:0]    snap [10];
  logic          last, final_stop, go;
  always_comb begin
    snap[0] = 8'hA5;
    snap[1] = {3'b0, bus.hunger};
    snap[2] = {3'b0, bus.happiness};
    snap[3] = {3'b0, bus.health};
    snap[4] = {3'b0, bus.hygiene};
    snap[5] = {3'b0, bus.energy};
    snap[6] = {3'b0, bus.social};
    snap[7] = bus.status;
    snap[8] = {7'b0, bus.is_sleeping};
    snap[9] = {3'b0, bus.hunger ^ bus.happiness ^ bus.health ^ bus.hygiene ^ bus.energy ^ bus.social}
            ^ bus.status ^ {7'b0, bus.is_sleeping};
  end
  assign last           = cnt == CW'(CLKS_PER_BIT - 1);
  assign final_stop     = state == STOP && byte_idx == 4'd9 && last;
  assign go             = pending || bus.trigger;
  assign bus.frame_done = final_stop;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      pending  <= 1'b0;
      frame    <= '{default: 8'h00};
      bus.tx   <= 1'b1;
      bus.busy <= 1'b0;
    end else begin
      cnt     <= (state == IDLE || last) ? '0 : cnt + CW'(1);
      pending <= go && state != IDLE;
      case (state)
        IDLE: if (bus.trigger) begin
          frame    <= snap;
          byte_idx <= '0;
          state    <= START;
          bus.tx   <= 1'b0;
          bus.busy <= 1'b1;
        end
        START: if (last) begin
          state   <= DATA;
          bit_idx <= '0;
          bus.tx  <= frame[byte_idx][0];
        end
        DATA: if (last) begin
          bit_idx <= bit_idx + 3'd1;
          state   <= bit_idx == 3'd7 ? STOP : DATA;
          bus.tx  <= bit_idx == 3'd7 ? 1'b1 : frame[byte_idx][bit_idx + 3'd1];
        end
        STOP: if (last) begin
          if (byte_idx != 4'd9) begin
            byte_idx <= byte_idx + 4'd1;
            state    <= START;
            bus.tx   <= 1'b0;
          end else if (go) begin
            // back-to-back frame: fresh snapshot on the closing edge, busy never drops
            pending  <= 1'b0;
            frame    <= snap;
            byte_idx <= '0;
            state    <= START;
            bus.tx   <= 1'b0;
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule
